// File: rtl/uart_image_loader.sv
// uart_image_loader: packs received UART bytes big-endian into 16-bit words and
// writes them sequentially into SRAM from BASE_ADDR. An idle timeout ends the
// load (padding an odd trailing byte with 8'h00) and raises a sticky Load_done.
// Optional: define LOADER_CHECKSUM_EN to build a modulo-2^16 sum of written words.
module uart_image_loader #(
  parameter logic [17:0] BASE_ADDR      = 18'd0,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [17:0] MAX_WORDS      = 18'd262143
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [7:0]  RX_byte,
  input  logic        RX_valid,
  input  logic        RX_frame_error,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Load_done,
  output logic [17:0] Word_count,
  output logic [3:0]  Frame_error_count,
  output logic [15:0] Checksum
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LD_IDLE,
    S_LD_WAIT_HI,
    S_LD_WAIT_LO,
    S_LD_WRITE,
    S_LD_FLUSH,
    S_LD_DONE
  } ld_state_t;

  ld_state_t          state;
  logic [TIMER_W-1:0] idle_timer;
  logic [7:0]         high_byte;
  logic [17:0]        word_count_next;
  logic [3:0]         fe_count_next;

  // Count after the word currently being written is committed
  assign word_count_next = Word_count + 18'd1;

  // Saturating frame-error count for an accepted byte
  assign fe_count_next = (RX_frame_error && Frame_error_count != 4'hF) ?
                         Frame_error_count + 4'd1 : Frame_error_count;

  // Status flags decode directly from the state register
  assign Busy      = (state != S_LD_IDLE) && (state != S_LD_DONE);
  assign Load_done = (state == S_LD_DONE);

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_acc;

  // Running sum of every word, committed in the WRITE/FLUSH cycle
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      checksum_acc <= 16'h0000;
    end else if ((state == S_LD_IDLE || state == S_LD_DONE) && Start) begin
      checksum_acc <= 16'h0000;
    end else if (state == S_LD_WRITE || state == S_LD_FLUSH) begin
      checksum_acc <= checksum_acc + SRAM_write_data;
    end
  end

  assign Checksum = checksum_acc;
`else
  assign Checksum = 16'h0000;
`endif

  // Loader FSM with registered SRAM interface and counters
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state             <= S_LD_IDLE;
      SRAM_address      <= BASE_ADDR;
      SRAM_write_data   <= 16'h0000;
      SRAM_we_n         <= 1'b1;
      Word_count        <= 18'd0;
      Frame_error_count <= 4'h0;
      idle_timer        <= '0;
      high_byte         <= 8'h00;
    end else begin
      unique case (state)
        S_LD_IDLE, S_LD_DONE: begin
          // Incoming bytes are ignored until a new load is armed
          if (Start) begin
            Word_count        <= 18'd0;
            Frame_error_count <= 4'h0;
            idle_timer        <= '0;
            SRAM_address      <= BASE_ADDR;
            state             <= S_LD_WAIT_HI;
          end
        end

        S_LD_WAIT_HI: begin
          if (RX_valid) begin
            high_byte         <= RX_byte;
            Frame_error_count <= fe_count_next;
            idle_timer        <= '0;
            state             <= S_LD_WAIT_LO;
          end else if (idle_timer == TIMER_LAST) begin
            // Nothing received yet: keep waiting with the timer saturated
            if (Word_count != 18'd0) begin
              state <= S_LD_DONE;
            end
          end else begin
            idle_timer <= idle_timer + 1'b1;
          end
        end

        S_LD_WAIT_LO: begin
          if (RX_valid) begin
            SRAM_write_data   <= {high_byte, RX_byte};
            SRAM_we_n         <= 1'b0;
            Frame_error_count <= fe_count_next;
            idle_timer        <= '0;
            state             <= S_LD_WRITE;
          end else if (idle_timer == TIMER_LAST) begin
            // Odd trailing byte: pad and write it out
            SRAM_write_data <= {high_byte, 8'h00};
            SRAM_we_n       <= 1'b0;
            idle_timer      <= '0;
            state           <= S_LD_FLUSH;
          end else begin
            idle_timer <= idle_timer + 1'b1;
          end
        end

        S_LD_WRITE: begin
          SRAM_we_n    <= 1'b1;
          SRAM_address <= SRAM_address + 18'd1;
          Word_count   <= word_count_next;
          idle_timer   <= '0;
          if (word_count_next == MAX_WORDS) begin
            state <= S_LD_DONE;
          end else if (RX_valid) begin
            // Back-to-back byte becomes the next high byte
            high_byte         <= RX_byte;
            Frame_error_count <= fe_count_next;
            state             <= S_LD_WAIT_LO;
          end else begin
            state <= S_LD_WAIT_HI;
          end
        end

        S_LD_FLUSH: begin
          SRAM_we_n    <= 1'b1;
          SRAM_address <= SRAM_address + 18'd1;
          Word_count   <= word_count_next;
          state        <= S_LD_DONE;
        end

        default: begin
          state <= S_LD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_image_loader.sv
// tb_uart_image_loader: directed checks of uart_image_loader with a short timeout.
// A second instance with MAX_WORDS = 2 covers the word-limit path.
module tb_uart_image_loader;

  logic        CLOCK_50_I = 1'b0;
  logic        Resetn;
  logic        Start;
  logic        Start2;
  logic [7:0]  RX_byte;
  logic        RX_valid;
  logic        RX_frame_error;

  logic [17:0] SRAM_address, SRAM_address2;
  logic [15:0] SRAM_write_data, SRAM_write_data2;
  logic        SRAM_we_n, SRAM_we_n2;
  logic        Busy, Busy2;
  logic        Load_done, Load_done2;
  logic [17:0] Word_count, Word_count2;
  logic [3:0]  Frame_error_count, Frame_error_count2;
  logic [15:0] Checksum, Checksum2;

  int n_cmp = 0;
  int n_err = 0;

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  uart_image_loader #(
    .BASE_ADDR      (18'd100),
    .TIMEOUT_CYCLES (100),
    .MAX_WORDS      (18'd262143)
  ) dut (
    .CLOCK_50_I        (CLOCK_50_I),
    .Resetn            (Resetn),
    .Start             (Start),
    .RX_byte           (RX_byte),
    .RX_valid          (RX_valid),
    .RX_frame_error    (RX_frame_error),
    .SRAM_address      (SRAM_address),
    .SRAM_write_data   (SRAM_write_data),
    .SRAM_we_n         (SRAM_we_n),
    .Busy              (Busy),
    .Load_done         (Load_done),
    .Word_count        (Word_count),
    .Frame_error_count (Frame_error_count),
    .Checksum          (Checksum)
  );

  uart_image_loader #(
    .BASE_ADDR      (18'd100),
    .TIMEOUT_CYCLES (100),
    .MAX_WORDS      (18'd2)
  ) dut2 (
    .CLOCK_50_I        (CLOCK_50_I),
    .Resetn            (Resetn),
    .Start             (Start2),
    .RX_byte           (RX_byte),
    .RX_valid          (RX_valid),
    .RX_frame_error    (RX_frame_error),
    .SRAM_address      (SRAM_address2),
    .SRAM_write_data   (SRAM_write_data2),
    .SRAM_we_n         (SRAM_we_n2),
    .Busy              (Busy2),
    .Load_done         (Load_done2),
    .Word_count        (Word_count2),
    .Frame_error_count (Frame_error_count2),
    .Checksum          (Checksum2)
  );

  // SRAM write logs, one entry per low cycle of we_n
  logic [17:0] wr_addr  [0:63];
  logic [15:0] wr_data  [0:63];
  int          n_wr = 0;
  logic [17:0] wr_addr2 [0:7];
  logic [15:0] wr_data2 [0:7];
  int          n_wr2 = 0;

  always @(negedge CLOCK_50_I) begin
    if (!SRAM_we_n) begin
      if (n_wr < 64) begin
        wr_addr[n_wr] <= SRAM_address;
        wr_data[n_wr] <= SRAM_write_data;
      end
      n_wr <= n_wr + 1;
    end
  end

  always @(negedge CLOCK_50_I) begin
    if (!SRAM_we_n2) begin
      if (n_wr2 < 8) begin
        wr_addr2[n_wr2] <= SRAM_address2;
        wr_data2[n_wr2] <= SRAM_write_data2;
      end
      n_wr2 <= n_wr2 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50_I);
  endtask

  task automatic send(input logic [7:0] b, input logic fe, input int gap);
    RX_byte        = b;
    RX_valid       = 1'b1;
    RX_frame_error = fe;
    tick(1);
    RX_valid       = 1'b0;
    RX_frame_error = 1'b0;
    tick(gap);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!Load_done && k < 200) begin
      tick(1);
      k++;
    end
    check(tag, {31'd0, Load_done}, 32'd1);
  endtask

  initial begin
    Resetn         = 1'b0;
    Start          = 1'b0;
    Start2         = 1'b0;
    RX_byte        = 8'h00;
    RX_valid       = 1'b0;
    RX_frame_error = 1'b0;
    tick(3);
    Resetn = 1'b1;
    tick(2);

    // Reset state
    check("rst_addr", SRAM_address, 32'd100);
    check("rst_data", SRAM_write_data, 32'h0);
    check("rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Load_done}, 32'd0);
    check("rst_count", Word_count, 32'd0);
    check("rst_fec", Frame_error_count, 32'd0);
    check("rst_cs", Checksum, 32'd0);

    // Even byte count, ended by timeout
    Start = 1'b1; tick(1); Start = 1'b0;
    check("t1_busy", {31'd0, Busy}, 32'd1);
    send(8'h12, 1'b0, 2);
    send(8'h34, 1'b0, 2);
    send(8'h56, 1'b0, 2);
    send(8'h78, 1'b0, 0);
    tick(90);
    check("t1_early_done", {31'd0, Load_done}, 32'd0);
    wait_done("t1_done");
    check("t1_nwr", n_wr, 32'd2);
    check("t1_a0", wr_addr[0], 32'd100);
    check("t1_d0", wr_data[0], 32'h1234);
    check("t1_a1", wr_addr[1], 32'd101);
    check("t1_d1", wr_data[1], 32'h5678);
    check("t1_count", Word_count, 32'd2);
    check("t1_addr", SRAM_address, 32'd102);
    check("t1_busy_end", {31'd0, Busy}, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("t1_cs", Checksum, 32'h68AC);
`else
    check("t1_cs", Checksum, 32'h0);
`endif

    // Odd byte count: trailing byte flushed with zero pad
    Start = 1'b1; tick(1); Start = 1'b0;
    check("t2_count_clr", Word_count, 32'd0);
    check("t2_done_clr", {31'd0, Load_done}, 32'd0);
    send(8'hAB, 1'b0, 2);
    send(8'hCD, 1'b0, 2);
    send(8'hEF, 1'b0, 0);
    tick(90);
    check("t2_early_done", {31'd0, Load_done}, 32'd0);
    wait_done("t2_done");
    check("t2_nwr", n_wr, 32'd4);
    check("t2_a0", wr_addr[2], 32'd100);
    check("t2_d0", wr_data[2], 32'hABCD);
    check("t2_a1", wr_addr[3], 32'd101);
    check("t2_d1", wr_data[3], 32'hEF00);
    check("t2_count", Word_count, 32'd2);
`ifdef LOADER_CHECKSUM_EN
    check("t2_cs", Checksum, 32'h9ACD);
`else
    check("t2_cs", Checksum, 32'h0);
`endif

    // No bytes: the loader keeps waiting
    Start = 1'b1; tick(1); Start = 1'b0;
    tick(300);
    check("t3_busy", {31'd0, Busy}, 32'd1);
    check("t3_done", {31'd0, Load_done}, 32'd0);
    check("t3_nwr", n_wr, 32'd4);
    check("t3_count", Word_count, 32'd0);

    // Back-to-back bytes, 17 with frame errors; saturated timer must yield to RX_valid
    for (int i = 0; i < 18; i++) begin
      send(8'h10 + 8'(i), (i < 17) ? 1'b1 : 1'b0, 0);
    end
    wait_done("t5_done");
    check("t5_fec", Frame_error_count, 32'hF);
    check("t5_count", Word_count, 32'd9);
    check("t5_nwr", n_wr, 32'd13);
    check("t5_a_first", wr_addr[4], 32'd100);
    check("t5_d_first", wr_data[4], 32'h1011);
    check("t5_d_mid", wr_data[8], 32'h1819);
    check("t5_a_last", wr_addr[12], 32'd108);
    check("t5_d_last", wr_data[12], 32'h2021);
    check("t5_addr", SRAM_address, 32'd109);
`ifdef LOADER_CHECKSUM_EN
    check("t5_cs", Checksum, 32'hD8E1);
`else
    check("t5_cs", Checksum, 32'h0);
`endif

    // Word limit on the MAX_WORDS = 2 instance; first instance sits in DONE
    Start2 = 1'b1; tick(1); Start2 = 1'b0;
    send(8'h01, 1'b0, 2);
    send(8'h02, 1'b0, 2);
    send(8'h03, 1'b0, 2);
    send(8'h04, 1'b0, 2);
    check("t4_done_now", {31'd0, Load_done2}, 32'd1);
    check("t4_busy_now", {31'd0, Busy2}, 32'd0);
    send(8'h05, 1'b0, 2);
    send(8'h06, 1'b0, 2);
    check("t4_nwr", n_wr2, 32'd2);
    check("t4_a0", wr_addr2[0], 32'd100);
    check("t4_d0", wr_data2[0], 32'h0102);
    check("t4_a1", wr_addr2[1], 32'd101);
    check("t4_d1", wr_data2[1], 32'h0304);
    check("t4_count", Word_count2, 32'd2);
    check("t4_fec", Frame_error_count2, 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("t4_cs", Checksum2, 32'h0406);
`else
    check("t4_cs", Checksum2, 32'h0);
`endif
    check("t4_main_ignores", n_wr, 32'd13);

    // Reset mid-word, then a fresh load
    Start = 1'b1; tick(1); Start = 1'b0;
    send(8'h31, 1'b0, 2);
    send(8'h32, 1'b0, 2);
    send(8'h33, 1'b0, 2);
    check("t6_nwr_pre", n_wr, 32'd14);
    Resetn = 1'b0;
    #1;
    check("t6_rst_addr", SRAM_address, 32'd100);
    check("t6_rst_data", SRAM_write_data, 32'h0);
    check("t6_rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
    check("t6_rst_busy", {31'd0, Busy}, 32'd0);
    check("t6_rst_done", {31'd0, Load_done}, 32'd0);
    check("t6_rst_count", Word_count, 32'd0);
    check("t6_rst_fec", Frame_error_count, 32'd0);
    check("t6_rst_cs", Checksum, 32'd0);
    check("t6_rst_done2", {31'd0, Load_done2}, 32'd0);
    tick(2);
    Resetn = 1'b1;
    tick(1);
    check("t6_nwr_rst", n_wr, 32'd14);
    Start = 1'b1; tick(1); Start = 1'b0;
    send(8'h9A, 1'b0, 2);
    send(8'hBC, 1'b0, 3);
    check("t6_nwr", n_wr, 32'd15);
    check("t6_a", wr_addr[14], 32'd100);
    check("t6_d", wr_data[14], 32'h9ABC);
    check("t6_count", Word_count, 32'd1);
    check("t6_addr", SRAM_address, 32'd101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
